// File: rtl/scan_chain_serdes_if.sv
// Word streams between the scanner FIFO and the scan-chain serdes.
// The serdes takes the slave view; the scanner side takes the master view.
interface scan_chain_serdes_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    output s_tdata, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tvalid,
    output m_tready
  );

  modport slave (
    input  s_tdata, s_tvalid,
    output s_tready,
    output m_tdata, m_tvalid,
    input  m_tready
  );
endinterface

// File: rtl/scan_chain_serdes.sv
// Word-to-bit serializer for a scan chain, capturing the bits that leave the
// tail as words in the same pass (one pass is both a dump and a restore).
//
// state | meaning
// IDLE  | no scan in progress; zero-length start only pulses done
// LOAD  | s_tready high, waiting for the next input word
// SHIFT | scan_enable high, one chain bit per cycle, LSB first
// OUT   | m_tvalid high, captured word held until m_tready
module scan_chain_serdes #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] chain_len,
  scan_chain_serdes_if.slave   axs,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  rem;
  logic [DATA_WIDTH-1:0] wreg;
  logic [DATA_WIDTH-1:0] creg;
  logic [IDX_W-1:0]      idx;
  logic                  done_zl;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      rem     <= '0;
      wreg    <= '0;
      creg    <= '0;
      idx     <= '0;
      done_zl <= 1'b0;
    end else begin
      done_zl <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (chain_len != '0) begin
              rem   <= chain_len;
              state <= ST_LOAD;
            end else begin
              done_zl <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (axs.s_tvalid) begin
            wreg  <= axs.s_tdata;
            creg  <= '0;
            idx   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // scan_out is the tail bit before this edge's shift
          creg[idx] <= scan_out;
          idx       <= idx + IDX_W'(1);
          rem       <= rem - LEN_WIDTH'(1);
          if (idx == IDX_LAST || rem == LEN_WIDTH'(1))
            state <= ST_OUT;
        end
        ST_OUT: begin
          if (axs.m_tready)
            state <= (rem == '0) ? ST_IDLE : ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every handshake/enable output is a decode of the state register, so a
  // reset drops them immediately and stalls never enable the chain.
  assign axs.s_tready = (state == ST_LOAD);
  assign axs.m_tvalid = (state == ST_OUT);
  assign axs.m_tdata  = creg;
  assign scan_enable  = (state == ST_SHIFT);
  assign scan_in      = scan_enable & wreg[idx];
  assign busy         = (state != ST_IDLE);
  assign done         = done_zl | ((state == ST_OUT) && axs.m_tready && (rem == '0));
endmodule

// File: tb/tb_scan_chain_serdes.sv
// Directed bench for scan_chain_serdes with a behavioural scan chain
// (head at the top bit, tail at bit 0) and hand-computed expected words.
module tb_scan_chain_serdes;
  localparam int DW = 32;
  localparam int LW = 20;
  localparam int CH = 8448;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] chain_len = '0;
  logic          scan_enable, scan_in, busy, done;
  logic          scan_out;

  scan_chain_serdes_if #(.DATA_WIDTH(DW)) sif ();

  scan_chain_serdes #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .start       (start),
    .chain_len   (chain_len),
    .axs         (sif),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 aclk = ~aclk;

  logic [CH-1:0] chain = '0;
  logic [CH-1:0] chain_init = '0;
  logic [CH-1:0] tmp;
  logic          chain_load = 1'b0;
  int            cur_len = 32;
  int            shift_cnt = 0;
  int            done_cnt = 0;

  assign scan_out = chain[0];

  always @(posedge aclk) begin
    if (chain_load) chain <= chain_init;
    else if (scan_enable) begin
      tmp = chain >> 1;
      tmp[cur_len-1] = scan_in;
      chain <= tmp;
    end
    if (scan_enable) shift_cnt++;
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] dump1[$];
  int last_shifts, last_dones, bad_stall, bad_hold;

  task automatic preset_chain(input int len, input logic [CH-1:0] val);
    @(negedge aclk);
    cur_len = len;
    chain_init = val;
    chain_load = 1'b1;
    @(negedge aclk);
    chain_load = 1'b0;
  endtask

  // Drives one scan from in_q, collects out_q; optional stalls and a
  // second start pulse at loop cycle restart_at.
  task automatic run_scan(input int len, input int in_stall, input int out_stall,
                          input int restart_at);
    int in_i = 0;
    int s_cnt = 0;
    int cyc = 0;
    int sh0, dn0;
    logic [DW-1:0] held = '0;
    out_q.delete();
    bad_stall = 0;
    bad_hold = 0;
    sh0 = shift_cnt;
    dn0 = done_cnt;
    @(negedge aclk);
    start = 1'b1;
    chain_len = LW'(len);
    @(negedge aclk);
    start = 1'b0;
    chain_len = '0;
    check("busy_rise", {63'd0, busy}, 64'd1);
    check("s_tready_rise", {63'd0, sif.s_tready}, 64'd1);
    while (busy && cyc < 20000) begin
      sif.s_tvalid = 1'b0;
      sif.m_tready = 1'b0;
      if (sif.s_tready && in_i < in_q.size()) begin
        if (in_i == 1 && s_cnt < in_stall) begin
          s_cnt++;
          if (scan_enable) bad_stall++;
        end else begin
          sif.s_tvalid = 1'b1;
          sif.s_tdata = in_q[in_i];
          in_i++;
        end
      end
      if (sif.m_tvalid) begin
        if (out_q.size() == 0 && s_cnt >= 0 && held !== sif.m_tdata && cyc > 0 &&
            out_stall > 0 && bad_hold < 0) bad_hold++;
        if (out_q.size() == 0 && out_stall > 0) begin
          if (out_stall == 1 || held === '0) held = sif.m_tdata;
          else if (sif.m_tdata !== held) bad_hold++;
          if (scan_enable) bad_stall++;
          out_stall--;
        end else begin
          sif.m_tready = 1'b1;
          out_q.push_back(sif.m_tdata);
        end
      end
      if (cyc == restart_at) begin
        start = 1'b1;
        chain_len = LW'(8);
      end else begin
        start = 1'b0;
        chain_len = '0;
      end
      cyc++;
      @(negedge aclk);
    end
    sif.s_tvalid = 1'b0;
    sif.m_tready = 1'b0;
    start = 1'b0;
    check("scan_timeout", {63'd0, busy}, 64'd0);
    last_shifts = shift_cnt - sh0;
    last_dones = done_cnt - dn0;
  endtask

  initial begin
    logic [CH-1:0] pat;
    int sh0, dn0, cyc, bad;
    sif.s_tdata = '0;
    sif.s_tvalid = 1'b0;
    sif.m_tready = 1'b0;

    #1;
    check("rst_s_tready", {63'd0, sif.s_tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, sif.m_tvalid}, 64'd0);
    check("rst_scan_enable", {63'd0, scan_enable}, 64'd0);
    check("rst_scan_in", {63'd0, scan_in}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_m_tdata", {32'd0, sif.m_tdata}, 64'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    // single full word
    preset_chain(32, CH'(32'h1234_5678));
    in_q = '{32'hDEAD_BEEF};
    run_scan(32, 0, 0, -1);
    check("full_nout", 64'(out_q.size()), 64'd1);
    if (out_q.size() > 0) check("full_out0", {32'd0, out_q[0]}, 64'h1234_5678);
    check("full_chain", {32'd0, chain[31:0]}, 64'hDEAD_BEEF);
    check("full_done", 64'(last_dones), 64'd1);
    check("full_shifts", 64'(last_shifts), 64'd32);

    // partial last word
    preset_chain(40, CH'({8'hA5, 32'h0F0F_0F0F}));
    in_q = '{32'h1111_1111, 32'h0000_00C3};
    run_scan(40, 0, 0, -1);
    check("part_nout", 64'(out_q.size()), 64'd2);
    if (out_q.size() > 1) begin
      check("part_out0", {32'd0, out_q[0]}, 64'h0F0F_0F0F);
      check("part_out1", {32'd0, out_q[1]}, 64'h0000_00A5);
    end
    check("part_chain", {24'd0, chain[39:0]}, 64'hC3_1111_1111);
    check("part_shifts", 64'(last_shifts), 64'd40);

    // backpressure on both streams
    preset_chain(64, CH'(64'h0123_4567_89AB_CDEF));
    in_q = '{32'hCAFE_F00D, 32'h8BAD_F00D};
    run_scan(64, 5, 7, -1);
    check("bp_nout", 64'(out_q.size()), 64'd2);
    if (out_q.size() > 1) begin
      check("bp_out0", {32'd0, out_q[0]}, 64'h89AB_CDEF);
      check("bp_out1", {32'd0, out_q[1]}, 64'h0123_4567);
    end
    check("bp_chain", chain[63:0], 64'h8BAD_F00D_CAFE_F00D);
    check("bp_shifts", 64'(last_shifts), 64'd64);
    check("bp_stall_shift", 64'(bad_stall), 64'd0);
    check("bp_hold", 64'(bad_hold), 64'd0);
    check("bp_done", 64'(last_dones), 64'd1);

    // zero-length start
    @(negedge aclk);
    start = 1'b1;
    chain_len = '0;
    @(negedge aclk);
    start = 1'b0;
    check("zl_done", {63'd0, done}, 64'd1);
    check("zl_busy", {63'd0, busy}, 64'd0);
    check("zl_s_tready", {63'd0, sif.s_tready}, 64'd0);
    @(negedge aclk);
    check("zl_done_clr", {63'd0, done}, 64'd0);
    check("zl_m_tvalid", {63'd0, sif.m_tvalid}, 64'd0);

    // start while busy is ignored
    preset_chain(32, CH'(32'h0BAD_CAFE));
    in_q = '{32'h5555_AAAA};
    run_scan(32, 0, 0, 6);
    check("sb_shifts", 64'(last_shifts), 64'd32);
    check("sb_done", 64'(last_dones), 64'd1);
    check("sb_nout", 64'(out_q.size()), 64'd1);
    if (out_q.size() > 0) check("sb_out0", {32'd0, out_q[0]}, 64'h0BAD_CAFE);
    @(negedge aclk);
    check("sb_idle", {63'd0, busy}, 64'd0);

    // reset during shift
    preset_chain(32, CH'(32'hFFFF_0000));
    sh0 = shift_cnt;
    dn0 = done_cnt;
    @(negedge aclk);
    start = 1'b1;
    chain_len = LW'(32);
    @(negedge aclk);
    start = 1'b0;
    cyc = 0;
    while (shift_cnt - sh0 < 10 && cyc < 100) begin
      sif.s_tvalid = sif.s_tready;
      sif.s_tdata = 32'h1357_9BDF;
      cyc++;
      @(negedge aclk);
    end
    sif.s_tvalid = 1'b0;
    check("rm_reached", 64'(shift_cnt - sh0), 64'd10);
    aresetn = 1'b0;
    #1;
    check("rm_scan_enable", {63'd0, scan_enable}, 64'd0);
    check("rm_busy", {63'd0, busy}, 64'd0);
    check("rm_m_tvalid", {63'd0, sif.m_tvalid}, 64'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rm_no_done", 64'(done_cnt - dn0), 64'd0);
    preset_chain(32, CH'(32'h0F1E_2D3C));
    in_q = '{32'h4B5A_6978};
    run_scan(32, 0, 0, -1);
    if (out_q.size() > 0) check("rm_fresh_out", {32'd0, out_q[0]}, 64'h0F1E_2D3C);
    else check("rm_fresh_nout", 64'd0, 64'd1);
    check("rm_fresh_chain", {32'd0, chain[31:0]}, 64'h4B5A_6978);

    // round trip over 264 words: dump, restore, dump again
    pat = '0;
    for (int w = 0; w < CH / DW; w++)
      pat[w*DW +: DW] = (w * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
    preset_chain(CH, pat);
    in_q.delete();
    for (int w = 0; w < CH / DW; w++) in_q.push_back(32'h0);
    run_scan(CH, 0, 0, -1);
    dump1 = out_q;
    check("rt_n1", 64'(dump1.size()), 64'(CH / DW));
    bad = 0;
    for (int w = 0; w < dump1.size(); w++)
      if (dump1[w] !== pat[w*DW +: DW]) bad++;
    check("rt_dump1", 64'(bad), 64'd0);
    in_q = dump1;
    run_scan(CH, 0, 0, -1);
    check("rt_restore", {63'd0, chain === pat}, 64'd1);
    in_q = dump1;
    run_scan(CH, 0, 0, -1);
    check("rt_n2", 64'(out_q.size()), 64'(CH / DW));
    bad = 0;
    for (int w = 0; w < out_q.size() && w < dump1.size(); w++)
      if (out_q[w] !== dump1[w]) bad++;
    check("rt_dump2", 64'(bad), 64'd0);
    check("rt_shifts", 64'(last_shifts), 64'(CH));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
